// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready handshake on both sides.
// Shifts run 1 bit/cycle unless FAST_SHIFT is set; everything else takes one cycle.
module alu_exec_unit #(
  parameter int unsigned WIDTH      = 32,
  parameter bit          FAST_SHIFT = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_control,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy
);

  localparam int unsigned SW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] acc_q;
  logic [SW-1:0]    cnt_q;
  logic [1:0]       kind_q;

  logic             accept;
  logic             is_shift;
  logic             start_iter;
  logic [SW-1:0]    shamt;
  logic [WIDTH-1:0] calc;
  logic [WIDTH-1:0] acc_step;

  assign shamt      = op_b[SW-1:0];
  assign in_ready   = (state_q == StIdle) || ((state_q == StDone) && out_ready);
  assign busy       = (state_q == StShift);
  assign accept     = in_valid && in_ready;
  assign is_shift   = (alu_control == 4'b1000) || (alu_control == 4'b1001) ||
                      (alu_control == 4'b1010);
  assign start_iter = is_shift && (shamt != '0) && !FAST_SHIFT;

  // Single-cycle result; without FAST_SHIFT it only sees shifts with shamt==0.
  always_comb begin
    calc = '0;
    case (alu_control)
      4'b0000: calc = op_a + op_b;
      4'b0001: calc = op_a - op_b;
      4'b0010: calc = op_a & op_b;
      4'b0011: calc = op_a | op_b;
      4'b0100: calc = op_a ^ op_b;
      4'b0110: calc = {{(WIDTH-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      4'b0111: calc = {{(WIDTH-1){1'b0}}, op_a < op_b};
      4'b1000: calc = FAST_SHIFT ? (op_a << shamt) : op_a;
      4'b1001: calc = FAST_SHIFT ? (op_a >> shamt) : op_a;
      4'b1010: calc = FAST_SHIFT ? $unsigned($signed(op_a) >>> shamt) : op_a;
      default: calc = '0;
    endcase
  end

  // kind_q holds alu_control[1:0] of the shift: 00 SLL, 01 SRL, 10 SRA.
  always_comb begin
    acc_step = '0;
    case (kind_q)
      2'b00:   acc_step = {acc_q[WIDTH-2:0], 1'b0};
      2'b01:   acc_step = {1'b0, acc_q[WIDTH-1:1]};
      default: acc_step = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      acc_q     <= '0;
      cnt_q     <= '0;
      kind_q    <= '0;
    end else begin
      case (state_q)
        StShift: begin
          acc_q <= acc_step;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == SW'(1)) begin
            result    <= acc_step;
            zero      <= (acc_step == '0);
            out_valid <= 1'b1;
            state_q   <= StDone;
          end
        end
        StIdle, StDone: begin
          if (accept) begin
            if (start_iter) begin
              acc_q     <= op_a;
              cnt_q     <= shamt;
              kind_q    <= alu_control[1:0];
              out_valid <= 1'b0;
              state_q   <= StShift;
            end else begin
              result    <= calc;
              zero      <= (calc == '0);
              out_valid <= 1'b1;
              state_q   <= StDone;
            end
          end else if ((state_q == StDone) && out_ready) begin
            out_valid <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state_q   <= StIdle;
        end
      endcase
    end
  end

endmodule
